// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor controller.
package serial_add_ctrl_pkg;

    localparam int unsigned N_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Bit-counter width for an n-bit serial operation (at least one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Start/done handshake and operand/result bus of the serial adder.
interface serial_add_ctrl_if
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         sub;
    logic         busy;
    logic         done;
    logic [N-1:0] Sum;
    logic         C_out;
    logic         Ofl;
    logic         err;

    modport master (
        output start, A, B, sub,
        input  busy, done, Sum, C_out, Ofl, err
    );

    modport slave (
        input  start, A, B, sub,
        output busy, done, Sum, C_out, Ofl, err
    );
endinterface

// File: rtl/dff.sv
// Standard register cell: synchronous active-high reset, load enable.
module dff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    // Reset has priority over the load enable
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end
endmodule

// File: rtl/fullAdder_1b.sv
// Single-bit full adder cell; o_err is a reserved status bit, always low here.
module fullAdder_1b (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout,
    output logic o_err
);
    assign o_s    = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
    assign o_err  = 1'b0;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit adder/subtractor: one full adder, LSB first, start/done handshake.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    serial_add_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W = cnt_w(N);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic             w_dp_en;

    logic [N-1:0]     r_opa;
    logic [N-1:0]     r_opb;
    logic [N-1:0]     r_res;
    logic [N-1:0]     r_sum;
    logic [N-1:0]     w_opa_d;
    logic [N-1:0]     w_opb_d;
    logic [N-1:0]     w_res_d;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;
    logic             r_carry;
    logic             w_carry_d;
    logic             r_cout;
    logic             r_ofl;
    logic             r_busy;
    logic             r_done;
    logic             r_err;
    logic             w_busy_d;
    logic             w_done_d;
    logic             w_err_d;
    logic             w_ofl_d;

    logic             w_fa_s;
    logic             w_fa_cout;
    logic             w_fa_err_unused;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath control strobes
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_last       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                w_step = 1'b1;
                if (r_cnt == CNT_W'(N - 1)) begin
                    w_last       = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    w_load       = 1'b1;
                    w_next_state = ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Datapath next values: capture on load, shift right one bit per step
    always_comb begin
        w_dp_en   = w_load | w_step;
        w_opa_d   = w_load ? bus.A : {1'b0, r_opa[N-1:1]};
        w_opb_d   = w_load ? (bus.sub ? ~bus.B : bus.B) : {1'b0, r_opb[N-1:1]};
        w_carry_d = w_load ? bus.sub : w_fa_cout;
        w_cnt_d   = w_load ? '0 : r_cnt + CNT_W'(1);
        w_res_d   = {w_fa_s, r_res[N-1:1]};
        // r_carry is the carry into the MSB while the last bit is summed
        w_ofl_d   = r_carry ^ w_fa_cout;
        w_busy_d  = (w_next_state == ST_RUN);
        w_done_d  = (w_next_state == ST_DONE);
        w_err_d   = bus.start & (r_state == ST_RUN);
    end

    fullAdder_1b u_fa (
        .i_a    (r_opa[0]),
        .i_b    (r_opb[0]),
        .i_cin  (r_carry),
        .o_s    (w_fa_s),
        .o_cout (w_fa_cout),
        .o_err  (w_fa_err_unused)
    );

    dff #(.W(N))     u_opa   (.clk(clk), .rst(rst), .i_en(w_dp_en), .i_d(w_opa_d),   .o_q(r_opa));
    dff #(.W(N))     u_opb   (.clk(clk), .rst(rst), .i_en(w_dp_en), .i_d(w_opb_d),   .o_q(r_opb));
    dff #(.W(1))     u_carry (.clk(clk), .rst(rst), .i_en(w_dp_en), .i_d(w_carry_d), .o_q(r_carry));
    dff #(.W(CNT_W)) u_cnt   (.clk(clk), .rst(rst), .i_en(w_dp_en), .i_d(w_cnt_d),   .o_q(r_cnt));
    dff #(.W(N))     u_res   (.clk(clk), .rst(rst), .i_en(w_step),  .i_d(w_res_d),   .o_q(r_res));

    // Visible results change only on entry to DONE
    dff #(.W(N))     u_sum   (.clk(clk), .rst(rst), .i_en(w_last),  .i_d(w_res_d),   .o_q(r_sum));
    dff #(.W(1))     u_cout  (.clk(clk), .rst(rst), .i_en(w_last),  .i_d(w_fa_cout), .o_q(r_cout));
    dff #(.W(1))     u_ofl   (.clk(clk), .rst(rst), .i_en(w_last),  .i_d(w_ofl_d),   .o_q(r_ofl));

    dff #(.W(1))     u_busy  (.clk(clk), .rst(rst), .i_en(1'b1),    .i_d(w_busy_d),  .o_q(r_busy));
    dff #(.W(1))     u_done  (.clk(clk), .rst(rst), .i_en(1'b1),    .i_d(w_done_d),  .o_q(r_done));
    dff #(.W(1))     u_err   (.clk(clk), .rst(rst), .i_en(1'b1),    .i_d(w_err_d),   .o_q(r_err));

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.err   = r_err;
    assign bus.Sum   = r_sum;
    assign bus.C_out = r_cout;
    assign bus.Ofl   = r_ofl;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (N=16): cycle model plus directed vectors.
module tb_serial_add_ctrl;
    localparam int N = 16;

    logic clk;
    logic rst;

    serial_add_ctrl_if #(.N(N)) bus ();

    serial_add_ctrl #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;
    bit cmp_en   = 1'b0;

    typedef struct packed {
        logic [N-1:0] sum;
        logic         c;
        logic         o;
    } res_t;

    // Expected result from plain modular arithmetic
    function automatic res_t calc(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        res_t       r;
        logic [N:0] full;
        if (!s) begin
            full  = {1'b0, a} + {1'b0, b};
            r.sum = full[N-1:0];
            r.c   = full[N];
            r.o   = (a[N-1] == b[N-1]) && (r.sum[N-1] != a[N-1]);
        end else begin
            r.sum = a - b;
            r.c   = (a >= b);
            r.o   = (a[N-1] != b[N-1]) && (r.sum[N-1] != a[N-1]);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model: phase 0 = idle, 1..N = operation in flight, N+1 = result cycle
    int           m_phase = 0;
    logic [N-1:0] m_a = '0;
    logic [N-1:0] m_b = '0;
    logic         m_s = 1'b0;
    res_t         m_res = '0;
    logic         m_err = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase <= 0;
            m_res   <= '0;
            m_err   <= 1'b0;
        end else begin
            m_err <= bus.start && (m_phase >= 1) && (m_phase <= N);
            if ((m_phase == 0 || m_phase == N + 1) && bus.start) begin
                m_a     <= bus.A;
                m_b     <= bus.B;
                m_s     <= bus.sub;
                m_phase <= 1;
            end else if (m_phase >= 1 && m_phase < N) begin
                m_phase <= m_phase + 1;
            end else if (m_phase == N) begin
                m_phase <= N + 1;
                m_res   <= calc(m_a, m_b, m_s);
            end else begin
                m_phase <= 0;
            end
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy",  32'(bus.busy),  32'((m_phase >= 1) && (m_phase <= N)));
            chk("done",  32'(bus.done),  32'(m_phase == N + 1));
            chk("err",   32'(bus.err),   32'(m_err));
            chk("Sum",   32'(bus.Sum),   32'(m_res.sum));
            chk("C_out", 32'(bus.C_out), 32'(m_res.c));
            chk("Ofl",   32'(bus.Ofl),   32'(m_res.o));
        end
    end

    // Present one operation; returns just after the accepting edge with start dropped
    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        @(posedge clk);
        #1;
        bus.A = a; bus.B = b; bus.sub = s; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for done; cyc = base + cycles waited, or -1 on timeout
    task automatic wait_done(input int base, output int cyc);
        cyc = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (bus.done) begin
                cyc = base + n;
                break;
            end
        end
        if (cyc < 0) chk("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic expect_result(input string tag, input int cyc, input int req_cyc,
                                 input logic [N-1:0] s, input logic c, input logic o);
        chk({tag, "_cycle"}, 32'(cyc), 32'(req_cyc));
        chk({tag, "_sum"},   32'(bus.Sum),   32'(s));
        chk({tag, "_cout"},  32'(bus.C_out), 32'(c));
        chk({tag, "_ofl"},   32'(bus.Ofl),   32'(o));
    endtask

    int dc;

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cmp_en = 1'b1;

        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_done", 32'(bus.done), 32'(0));
        chk("rst_sum",  32'(bus.Sum),  32'(0));
        chk("rst_err",  32'(bus.err),  32'(0));

        // Signed overflow on addition
        launch(16'h7FFF, 16'h0001, 1'b0);
        wait_done(0, dc);
        expect_result("add_ovf", dc, 17, 16'h8000, 1'b0, 1'b1);
        chk("add_ovf_busy", 32'(bus.busy), 32'(0));

        // Subtraction with and without borrow
        launch(16'h0005, 16'h0007, 1'b1);
        wait_done(0, dc);
        expect_result("sub_borrow", dc, 17, 16'hFFFE, 1'b0, 1'b0);
        launch(16'h0007, 16'h0005, 1'b1);
        wait_done(0, dc);
        expect_result("sub_pos", dc, 17, 16'h0002, 1'b1, 1'b0);

        // Unsigned wrap and signed overflow on subtraction
        launch(16'hFFFF, 16'h0001, 1'b0);
        wait_done(0, dc);
        expect_result("add_wrap", dc, 17, 16'h0000, 1'b1, 1'b0);
        launch(16'h8000, 16'h0001, 1'b1);
        wait_done(0, dc);
        expect_result("sub_ovf", dc, 17, 16'h7FFF, 1'b1, 1'b1);

        // Start while busy: flagged, ignored
        launch(16'h1234, 16'h1111, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        bus.A = 16'hFFFF; bus.B = 16'hFFFF; bus.sub = 1'b1; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("err_c6", 32'(bus.err), 32'(1));
        @(negedge clk);
        chk("err_c7", 32'(bus.err), 32'(0));
        wait_done(7, dc);
        expect_result("busy_start", dc, 17, 16'h2345, 1'b0, 1'b0);

        // Reset mid-operation
        launch(16'h1111, 16'h2222, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(bus.busy), 32'(0));
        chk("midrst_done", 32'(bus.done), 32'(0));
        chk("midrst_sum",  32'(bus.Sum),  32'(0));
        launch(16'h0003, 16'h0004, 1'b0);
        wait_done(0, dc);
        expect_result("after_rst", dc, 17, 16'h0007, 1'b0, 1'b0);

        // Back-to-back with start held high
        @(posedge clk);
        #1;
        bus.A = 16'h0101; bus.B = 16'h0202; bus.sub = 1'b0; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.A = 16'h4000; bus.B = 16'h0001; bus.sub = 1'b1;
        wait_done(0, dc);
        expect_result("b2b_0", dc, 17, 16'h0303, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        bus.A = 16'hABCD; bus.B = 16'h1234; bus.sub = 1'b0;
        wait_done(17, dc);
        expect_result("b2b_1", dc, 34, 16'h3FFF, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(34, dc);
        expect_result("b2b_2", dc, 51, 16'hBE01, 1'b0, 1'b0);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
